axis_frame_pattern_gen: RTL and testbench

- Synthesizable AXI4-Stream frame source that drives the pixel stream consumed by x_trim on its aclk side.
- Emits Y_SIZE lines of byte-ramp data, 64-bit beats, with SOF/EOF/SOL/EOL on tuser and tlast on each line end.
- Honours tready backpressure and inserts a programmable inter-line gap.
- Serves as the on-chip stimulus source for the XGS datapath and for x_trim bring-up without a sensor.

---
 rtl/axis_video_pkg.sv | 44 ++++
 rtl/axis_frame_pattern_gen_if.sv | 14 +
 rtl/pattern_beat_builder.sv | 21 ++
 rtl/axis_frame_pattern_gen.sv | 178 +++++++++++++++++
 tb/tb_axis_frame_pattern_gen.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_video_pkg.sv
// Shared AXI4-Stream video definitions: tuser flag positions, generator FSM
// states and line geometry helpers used by the pattern source, x_trim and benches.
package axis_video_pkg;

  localparam int TUSER_SOF = 0;
  localparam int TUSER_EOF = 1;
  localparam int TUSER_SOL = 2;
  localparam int TUSER_EOL = 3;

  localparam int TDATA_W      = 64;
  localparam int TUSER_W      = 4;
  localparam int BEAT_W       = 13;
  localparam int LINE_BYTES_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LINE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Unsupported pixel widths fall back to one byte per pixel.
  function automatic logic [2:0] norm_pixel_width(input logic [2:0] pw);
    case (pw)
      3'd2:    return 3'd2;
      3'd4:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [LINE_BYTES_W-1:0] line_byte_count(input logic [12:0] x_size,
                                                              input logic [2:0]  pw);
    case (norm_pixel_width(pw))
      3'd4:    return {1'b0, x_size, 2'b00};
      3'd2:    return {2'b00, x_size, 1'b0};
      default: return {3'b000, x_size};
    endcase
  endfunction

  function automatic logic [BEAT_W-1:0] beat_count(input logic [12:0] x_size,
                                                   input logic [2:0]  pw);
    return BEAT_W'((line_byte_count(x_size, pw) + 16'd7) >> 3);
  endfunction

endpackage

// File: rtl/axis_frame_pattern_gen_if.sv
// AXI4-Stream video bus carrying 64-bit pixel beats with SOF/EOF/SOL/EOL on tuser.
interface axis_frame_pattern_gen_if;
  import axis_video_pkg::*;

  logic               tvalid;
  logic               tready;
  logic [TUSER_W-1:0] tuser;
  logic               tlast;
  logic [TDATA_W-1:0] tdata;

  modport master (output tvalid, tuser, tlast, tdata, input tready);
  modport slave  (input tvalid, tuser, tlast, tdata, output tready);

endinterface

// File: rtl/pattern_beat_builder.sv
// Combinational byte-ramp beat: byte i = base + seed + i for the valid lanes,
// zero in the unused upper lanes of a partial last beat.
module pattern_beat_builder
  import axis_video_pkg::*;
(
  input  logic [7:0]         byte_base,
  input  logic [7:0]         seed,
  input  logic [3:0]         valid_bytes,
  output logic [TDATA_W-1:0] beat
);

  always_comb begin
    beat = '0;
    for (int i = 0; i < TDATA_W / 8; i++) begin
      if (4'(i) < valid_bytes) begin
        beat[i*8 +: 8] = byte_base + seed + 8'(i);
      end
    end
  end

endmodule

// File: rtl/axis_frame_pattern_gen.sv
// AXI4-Stream frame source: emits y_size lines of byte-ramp beats with frame and
// line markers, honouring tready backpressure and a programmable inter-line gap.
module axis_frame_pattern_gen
  import axis_video_pkg::*;
#(
  parameter  int MAX_X_SIZE = 8191,
  parameter  int MAX_Y_SIZE = 4095,
  parameter  int GAP_WIDTH  = 16,
  localparam int XW = $clog2(MAX_X_SIZE + 1),
  localparam int YW = $clog2(MAX_Y_SIZE + 1)
) (
  input  logic                 aclk,
  input  logic                 aclk_reset_n,
  input  logic                 aclk_start,
  input  logic [2:0]           aclk_pixel_width,
  input  logic [XW-1:0]        aclk_x_size,
  input  logic [YW-1:0]        aclk_y_size,
  input  logic [GAP_WIDTH-1:0] aclk_line_gap,
  input  logic                 aclk_row_seed_en,
  output logic                 aclk_busy,
  output logic                 aclk_frame_done,
  output logic [15:0]          aclk_frame_cnt,
  axis_frame_pattern_gen_if.master axis
);

  state_t                  state_q, state_d;
  logic [LINE_BYTES_W-1:0] line_bytes_q, line_bytes_d;
  logic [BEAT_W-1:0]       beats_q, beats_d, beat_q, beat_d;
  logic [YW-1:0]           y_q, y_d, row_q, row_d;
  logic [GAP_WIDTH-1:0]    gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                    seed_en_q, seed_en_d;
  logic                    done_d;
  logic [15:0]             cnt_d;
  logic                    handshake, last_beat, last_row;

  logic [LINE_BYTES_W-1:0] byte_offset_d, remaining_d;
  logic [3:0]              valid_bytes_d;
  logic [7:0]              seed_d;
  logic [TDATA_W-1:0]      beat_data_d;
  logic [TUSER_W-1:0]      tuser_d;
  logic                    tlast_d, next_last_beat, next_last_row;

  logic                    tvalid_q, tlast_q;
  logic [TUSER_W-1:0]      tuser_q;
  logic [TDATA_W-1:0]      tdata_q;

  // Next-state logic; the frame geometry is captured only when a start is taken in idle.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    row_d        = row_q;
    gap_cnt_d    = gap_cnt_q;
    line_bytes_d = line_bytes_q;
    beats_d      = beats_q;
    y_d          = y_q;
    gap_d        = gap_q;
    seed_en_d    = seed_en_q;
    done_d       = 1'b0;
    cnt_d        = aclk_frame_cnt;
    handshake    = tvalid_q && axis.tready;
    last_beat    = (beat_q == beats_q - BEAT_W'(1));
    last_row     = (row_q == y_q - YW'(1));

    case (state_q)
      S_IDLE: begin
        if (aclk_start) begin
          line_bytes_d = line_byte_count(aclk_x_size, aclk_pixel_width);
          beats_d      = beat_count(aclk_x_size, aclk_pixel_width);
          y_d          = aclk_y_size;
          gap_d        = aclk_line_gap;
          seed_en_d    = aclk_row_seed_en;
          beat_d       = '0;
          row_d        = '0;
          if (aclk_x_size == '0 || aclk_y_size == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LINE;
          end
        end
      end
      S_LINE: begin
        if (handshake) begin
          if (!last_beat) begin
            beat_d = beat_q + BEAT_W'(1);
          end else if (last_row) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = aclk_frame_cnt + 16'd1;
          end else if (gap_q == '0) begin
            row_d  = row_q + YW'(1);
            beat_d = '0;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q - GAP_WIDTH'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_LINE;
          row_d   = row_q + YW'(1);
          beat_d  = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The beat is built from next-state values so the bus outputs can be registered
  // and still move one beat per cycle; while stalled the inputs do not change.
  always_comb begin
    byte_offset_d  = {beat_d, 3'b000};
    remaining_d    = line_bytes_d - byte_offset_d;
    valid_bytes_d  = (remaining_d >= 16'd8) ? 4'd8 : remaining_d[3:0];
    seed_d         = seed_en_d ? row_d[7:0] : 8'd0;
    next_last_beat = (beat_d == beats_d - BEAT_W'(1));
    next_last_row  = (row_d == y_d - YW'(1));
    tuser_d            = '0;
    tuser_d[TUSER_SOF] = (beat_d == '0) && (row_d == '0);
    tuser_d[TUSER_SOL] = (beat_d == '0) && (row_d != '0);
    tuser_d[TUSER_EOF] = next_last_beat && next_last_row;
    tuser_d[TUSER_EOL] = next_last_beat && !next_last_row;
    tlast_d            = next_last_beat;
  end

  pattern_beat_builder u_beat_builder (
    .byte_base   (byte_offset_d[7:0]),
    .seed        (seed_d),
    .valid_bytes (valid_bytes_d),
    .beat        (beat_data_d)
  );

  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      state_q         <= S_IDLE;
      beat_q          <= '0;
      row_q           <= '0;
      gap_cnt_q       <= '0;
      line_bytes_q    <= '0;
      beats_q         <= '0;
      y_q             <= '0;
      gap_q           <= '0;
      seed_en_q       <= 1'b0;
      tvalid_q        <= 1'b0;
      tdata_q         <= '0;
      tuser_q         <= '0;
      tlast_q         <= 1'b0;
      aclk_busy       <= 1'b0;
      aclk_frame_done <= 1'b0;
      aclk_frame_cnt  <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      row_q           <= row_d;
      gap_cnt_q       <= gap_cnt_d;
      line_bytes_q    <= line_bytes_d;
      beats_q         <= beats_d;
      y_q             <= y_d;
      gap_q           <= gap_d;
      seed_en_q       <= seed_en_d;
      tvalid_q        <= (state_d == S_LINE);
      tdata_q         <= (state_d == S_LINE) ? beat_data_d : '0;
      tuser_q         <= (state_d == S_LINE) ? tuser_d : '0;
      tlast_q         <= (state_d == S_LINE) && tlast_d;
      aclk_busy       <= (state_d != S_IDLE);
      aclk_frame_done <= done_d;
      aclk_frame_cnt  <= cnt_d;
    end
  end

  assign axis.tvalid = tvalid_q;
  assign axis.tdata  = tdata_q;
  assign axis.tuser  = tuser_q;
  assign axis.tlast  = tlast_q;

endmodule

// File: tb/tb_axis_frame_pattern_gen.sv
// Randomized bench for axis_frame_pattern_gen: a frame-level reference model
// predicts every beat, marker, gap length and frame_done/frame_cnt event.
module tb_axis_frame_pattern_gen;
  import axis_video_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
    int          gap_before;
    bit          check_gap;
  } beat_t;

  logic        aclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  pw = 3'd1;
  logic [12:0] x_size = '0;
  logic [11:0] y_size = '0;
  logic [15:0] line_gap = '0;
  logic        seed_en = 1'b0;
  logic        busy, frame_done;
  logic [15:0] frame_cnt;

  axis_frame_pattern_gen_if axis ();

  axis_frame_pattern_gen dut (
    .aclk             (aclk),
    .aclk_reset_n     (rst_n),
    .aclk_start       (start),
    .aclk_pixel_width (pw),
    .aclk_x_size      (x_size),
    .aclk_y_size      (y_size),
    .aclk_line_gap    (line_gap),
    .aclk_row_seed_en (seed_en),
    .aclk_busy        (busy),
    .aclk_frame_done  (frame_done),
    .aclk_frame_cnt   (frame_cnt),
    .axis             (axis)
  );

  initial forever #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  int          frames_seen = 0;
  logic [15:0] exp_cnt = '0;
  bit          zero_done_flag = 1'b0;
  bit          rand_ready = 1'b0;
  beat_t       exp_q[$];
  beat_t       obs_q[$];

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference frame: byte b of row r is (b + seed) mod 256 over x*pw bytes per line.
  task automatic build_frame(input int pw_in, input int x_in, input int y_in,
                             input int gap_in, input bit seed_in);
    int    pwb, nbytes, nbeats, off, seed;
    beat_t b;
    pwb    = (pw_in == 2) ? 2 : (pw_in == 4) ? 4 : 1;
    nbytes = x_in * pwb;
    nbeats = (nbytes + 7) / 8;
    for (int r = 0; r < y_in; r++) begin
      seed = seed_in ? (r % 256) : 0;
      for (int bt = 0; bt < nbeats; bt++) begin
        b.data = '0;
        for (int k = 0; k < 8; k++) begin
          off = bt * 8 + k;
          if (off < nbytes) b.data[k*8 +: 8] = 8'((off + seed) % 256);
        end
        b.user = '0;
        if (bt == 0) begin
          if (r == 0) b.user[TUSER_SOF] = 1'b1;
          else        b.user[TUSER_SOL] = 1'b1;
        end
        if (bt == nbeats - 1) begin
          if (r == y_in - 1) b.user[TUSER_EOF] = 1'b1;
          else               b.user[TUSER_EOL] = 1'b1;
        end
        b.last       = (bt == nbeats - 1);
        b.check_gap  = (bt != 0) || (r != 0);
        b.gap_before = (bt == 0) ? gap_in : 0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic scramble_config();
    pw       = 3'($urandom_range(0, 7));
    x_size   = 13'($urandom_range(1, 8191));
    y_size   = 12'($urandom_range(1, 4095));
    line_gap = 16'($urandom);
    seed_en  = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_stimulus(input int pw_in, input int x_in, input int y_in,
                                input int gap_in, input bit seed_in);
    bit zero;
    zero = (x_in == 0) || (y_in == 0);
    @(posedge aclk); #1;
    pw = 3'(pw_in); x_size = 13'(x_in); y_size = 12'(y_in);
    line_gap = 16'(gap_in); seed_en = seed_in; start = 1'b1;
    if (!zero) build_frame(pw_in, x_in, y_in, gap_in, seed_in);
    @(posedge aclk); #1;
    start = 1'b0;
    scramble_config();
    if (zero) begin
      zero_done_flag = 1'b1;
      @(posedge aclk); #1;
      zero_done_flag = 1'b0;
    end
  endtask

  task automatic pulse_start_only();
    @(posedge aclk); #1;
    scramble_config();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int budget;
    budget = 20000;
    while ((frames_seen < target || exp_q.size() != 0) && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL frame_timeout: frames %0d pending beats %0d, expected frames %0d",
               frames_seen, exp_q.size(), target);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic run_frame(input int pw_in, input int x_in, input int y_in,
                           input int gap_in, input bit seed_in);
    int target;
    target = frames_seen + 1;
    apply_stimulus(pw_in, x_in, y_in, gap_in, seed_in);
    wait_frames(target);
  endtask

  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every cycle checks done/count, stall stability and each handshaked beat.
  initial begin
    bit    stalled, prev_eof;
    int    idle_run;
    beat_t held, e, o;
    stalled = 0; prev_eof = 0; idle_run = 0;
    forever begin
      @(negedge aclk);
      if (!rst_n) begin
        stalled = 0; prev_eof = 0; idle_run = 0;
      end else begin
        check_output("frame_done", 64'(frame_done), 64'(prev_eof || zero_done_flag));
        check_output("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        prev_eof = 0;
        if (stalled) begin
          check_output("stall_tvalid", 64'(axis.tvalid), 64'd1);
          check_output("stall_tdata", axis.tdata, held.data);
          check_output("stall_tuser", 64'(axis.tuser), 64'(held.user));
          check_output("stall_tlast", 64'(axis.tlast), 64'(held.last));
        end
        if (axis.tvalid) check_output("busy_while_valid", 64'(busy), 64'd1);
        if (axis.tvalid && axis.tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL extra_beat: got tdata 0x%0h tuser %b, expected no beat",
                     axis.tdata, axis.tuser);
          end else begin
            e = exp_q.pop_front();
            check_output("tdata", axis.tdata, e.data);
            check_output("tuser", 64'(axis.tuser), 64'(e.user));
            check_output("tlast", 64'(axis.tlast), 64'(e.last));
            if (e.check_gap) check_output("idle_cycles", 64'(idle_run), 64'(e.gap_before));
            o.data = axis.tdata; o.user = axis.tuser; o.last = axis.tlast;
            o.gap_before = idle_run; o.check_gap = 0;
            obs_q.push_back(o);
            if (e.user[TUSER_EOF]) begin
              exp_cnt = exp_cnt + 16'd1;
              frames_seen++;
              prev_eof = 1;
            end
          end
          idle_run = 0;
        end else if (!axis.tvalid) begin
          idle_run++;
        end
        stalled = axis.tvalid && !axis.tready;
        held.data = axis.tdata; held.user = axis.tuser; held.last = axis.tlast;
      end
    end
  end

  initial begin
    int budget;
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_tvalid", 64'(axis.tvalid), 64'd0);
    check_output("reset_tuser", 64'(axis.tuser), 64'd0);
    check_output("reset_tlast", 64'(axis.tlast), 64'd0);
    check_output("reset_tdata", axis.tdata, 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_frame_done", 64'(frame_done), 64'd0);
    check_output("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    repeat (2) @(posedge aclk);
    #3 rst_n = 1'b1;

    // 256-pixel byte ramp, continuous ready.
    rand_ready = 0; obs_q.delete();
    run_frame(1, 256, 4, 0, 0);
    check_output("ramp_beat_count", 64'(obs_q.size()), 64'd128);
    if (obs_q.size() == 128) begin
      check_output("ramp_first_data", obs_q[0].data, 64'h0706050403020100);
      check_output("ramp_first_user", 64'(obs_q[0].user), 64'b0001);
      check_output("ramp_last_data", obs_q[127].data, 64'hFFFEFDFCFBFAF9F8);
      check_output("ramp_last_user", 64'(obs_q[127].user), 64'b0010);
      check_output("ramp_last_tlast", 64'(obs_q[127].last), 64'd1);
    end

    // Same frame under random backpressure.
    rand_ready = 1;
    run_frame(1, 256, 4, 0, 0);

    // Two-byte pixels, row seeding, partial last beat.
    rand_ready = 0; obs_q.delete();
    run_frame(2, 13, 2, 0, 1);
    check_output("pw2_beat_count", 64'(obs_q.size()), 64'd8);
    if (obs_q.size() == 8) begin
      check_output("pw2_row1_beat0", obs_q[4].data, 64'h0807060504030201);
      check_output("pw2_row1_beat3", obs_q[7].data, 64'h0000000000001A19);
      check_output("pw2_row1_beat3_user", 64'(obs_q[7].user), 64'b0010);
    end

    // Empty frames produce only a frame_done pulse.
    apply_stimulus(1, 0, 3, 0, 0);
    repeat (4) @(negedge aclk);
    apply_stimulus(4, 7, 0, 0, 0);
    repeat (4) @(negedge aclk);

    // Single-beat frame.
    obs_q.delete();
    run_frame(1, 1, 1, 0, 0);
    check_output("one_beat_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) begin
      check_output("one_beat_user", 64'(obs_q[0].user), 64'b0011);
      check_output("one_beat_data", obs_q[0].data, 64'd0);
      check_output("one_beat_tlast", 64'(obs_q[0].last), 64'd1);
    end

    for (int t = 0; t < 6; t++) begin
      rand_ready = 1'($urandom_range(0, 1));
      run_frame($urandom_range(0, 7), $urandom_range(1, 40), $urandom_range(1, 4),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-frame around row 2 beat 10.
    rand_ready = 0; obs_q.delete();
    apply_stimulus(1, 256, 4, 2, 0);
    budget = 2000;
    while (obs_q.size() < 74 && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    @(posedge aclk); #3;
    check_output("tvalid_before_reset", 64'(axis.tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_tvalid", 64'(axis.tvalid), 64'd0);
    check_output("async_reset_busy", 64'(busy), 64'd0);
    check_output("async_reset_frame_cnt", 64'(frame_cnt), 64'd0);
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(posedge aclk);
    #3 rst_n = 1'b1;

    // Gap of 5 between lines, an ignored start mid-frame, clean SOF after reset.
    obs_q.delete();
    apply_stimulus(1, 20, 3, 5, 1);
    budget = 2000;
    while (obs_q.size() < 2 && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    pulse_start_only();
    wait_frames(frames_seen + 1);
    repeat (6) @(negedge aclk);
    check_output("gap_beat_count", 64'(obs_q.size()), 64'd9);
    if (obs_q.size() == 9) check_output("post_reset_sof", 64'(obs_q[0].user), 64'b0001);
    check_output("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
